// File: rtl/tag_sort_sched_pkg.sv
// Shared definitions for the tag-sort occupancy scheduler.
package tag_sort_pkg;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned NTAGS = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SRCH = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Mask with every bit at index >= ptr set.
  function automatic logic [NTAGS-1:0] ge_mask(input logic [TAG_W-1:0] ptr);
    return {NTAGS{1'b1}} << ptr;
  endfunction

endpackage

// File: rtl/tag_sort_sched_if.sv
// Insert/dequeue handshake and status bundle for tag_sort_sched.
interface tag_sort_sched_if;
  import tag_sort_pkg::*;

  logic             ins_valid;
  logic [TAG_W-1:0] ins_tag;
  logic             ins_ready;
  logic             deq_req;
  logic             deq_ready;
  logic             deq_valid;
  logic [TAG_W-1:0] deq_tag;
  logic             deq_empty;
  logic [TAG_W-1:0] cur_ptr;
  logic [NTAGS-1:0] occ;

  modport master (
    output ins_valid, ins_tag, deq_req,
    input  ins_ready, deq_ready, deq_valid, deq_tag, deq_empty, cur_ptr, occ
  );

  modport slave (
    input  ins_valid, ins_tag, deq_req,
    output ins_ready, deq_ready, deq_valid, deq_tag, deq_empty, cur_ptr, occ
  );

endinterface

// File: rtl/tag_sort_sched_search.sv
// Circular first-set search over the 16-bit occupancy mask.
module tag_search16
  import tag_sort_pkg::*;
(
  input  logic [NTAGS-1:0] mask,
  input  logic [TAG_W-1:0] start,
  input  logic             wrap_en,
  output logic [TAG_W-1:0] idx,
  output logic             found
);

  logic [NTAGS-1:0] hi_mask;
  logic [NTAGS-1:0] pick;

  // Prefer tags at/after start; fall back to the whole mask only when wrapping.
  always_comb begin
    hi_mask = mask & ge_mask(start);
    if (|hi_mask) begin
      pick = hi_mask;
    end else if (wrap_en) begin
      pick = mask;
    end else begin
      pick = '0;
    end
    found = |pick;
    idx   = '0;
    for (int unsigned i = NTAGS; i > 0; i--) begin
      if (pick[i-1]) begin
        idx = TAG_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/tag_sort_sched.sv
// Per-tag pending counters, occupancy mask and 3-cycle dequeue sequencer.
module tag_sort_sched
  import tag_sort_pkg::*;
#(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  tag_sort_sched_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic             WRAP_EN = (WRAP != 0);

  logic [CNT_W-1:0] cnt      [NTAGS];
  logic [CNT_W-1:0] cnt_next [NTAGS];
  logic [NTAGS-1:0] occ_q;
  logic [NTAGS-1:0] occ_next;
  logic [TAG_W-1:0] ptr_q;
  state_t           state_q;
  state_t           state_next;
  logic             deq_valid_q;
  logic [TAG_W-1:0] deq_tag_q;
  logic             deq_empty_q;

  logic             ins_fire;
  logic             dec_fire;
  logic             srch_found;
  logic [TAG_W-1:0] srch_idx;

  assign bus.ins_ready = (cnt[bus.ins_tag] != CNT_MAX);
  assign ins_fire      = bus.ins_valid & bus.ins_ready;
  assign bus.deq_ready = (state_q == ST_IDLE);
  assign dec_fire      = (state_q == ST_SRCH) & srch_found;

  assign bus.deq_valid = deq_valid_q;
  assign bus.deq_tag   = deq_tag_q;
  assign bus.deq_empty = deq_empty_q;
  assign bus.cur_ptr   = ptr_q;
  assign bus.occ       = occ_q;

  tag_search16 u_search (
    .mask    (occ_q),
    .start   (ptr_q),
    .wrap_en (WRAP_EN),
    .idx     (srch_idx),
    .found   (srch_found)
  );

  // Next counter values; an insert and a decrement on the same tag cancel.
  always_comb begin
    for (int unsigned i = 0; i < NTAGS; i++) begin
      cnt_next[i] = cnt[i];
      if ((ins_fire && bus.ins_tag == TAG_W'(i)) && !(dec_fire && srch_idx == TAG_W'(i))) begin
        cnt_next[i] = cnt[i] + CNT_W'(1);
      end else if (!(ins_fire && bus.ins_tag == TAG_W'(i)) && (dec_fire && srch_idx == TAG_W'(i))) begin
        cnt_next[i] = cnt[i] - CNT_W'(1);
      end
      occ_next[i] = (cnt_next[i] != '0);
    end
  end

  // Dequeue sequencer: IDLE -> SRCH -> RESP -> IDLE.
  always_comb begin
    state_next = ST_IDLE;
    case (state_q)
      ST_IDLE: state_next = bus.deq_req ? ST_SRCH : ST_IDLE;
      ST_SRCH: state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Counter array and registered occupancy mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NTAGS; i++) begin
        cnt[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      cnt   <= cnt_next;
      occ_q <= occ_next;
    end
  end

  // FSM state, round pointer and dequeue result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      deq_valid_q <= 1'b0;
      deq_tag_q   <= '0;
      deq_empty_q <= 1'b0;
    end else begin
      state_q     <= state_next;
      deq_valid_q <= (state_q == ST_SRCH);
      if (state_q == ST_SRCH) begin
        if (srch_found) begin
          ptr_q       <= srch_idx;
          deq_tag_q   <= srch_idx;
          deq_empty_q <= 1'b0;
        end else begin
          deq_tag_q   <= ptr_q;
          deq_empty_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tag_sort_sched.sv
// Self-checking bench for tag_sort_sched: directed table, corner sequences
// and randomized traffic against a per-instance reference model.
module tb_tag_sort_sched;

  localparam int K_RST = 0;
  localparam int K_INS = 1;
  localparam int K_DEQ = 2;

  typedef struct {
    int kind;
    int tag;
    int reps;
    int e_tag1;
    int e_emp1;
    int e_ptr1;
    int e_tag0;
    int e_emp0;
    int e_ptr0;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ins_valid = 1'b0;
  logic [3:0] ins_tag = '0;
  logic       deq_req = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference state, index 1 = WRAP=1 instance, index 0 = WRAP=0 instance.
  int mcnt   [2][16];
  int mptr   [2];
  int mphase [2];
  int mtag   [2];
  int mempty [2];
  int mvalid [2];

  int cap_v   [2];
  int cap_tag [2];
  int cap_emp [2];
  int cap_ptr [2];

  always #5 clk = ~clk;

  tag_sort_sched_if ifw1 ();
  tag_sort_sched_if ifw0 ();

  assign ifw1.ins_valid = ins_valid;
  assign ifw1.ins_tag   = ins_tag;
  assign ifw1.deq_req   = deq_req;
  assign ifw0.ins_valid = ins_valid;
  assign ifw0.ins_tag   = ins_tag;
  assign ifw0.deq_req   = deq_req;

  tag_sort_sched #(.CNT_W(4), .WRAP(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifw1.slave)
  );

  tag_sort_sched #(.CNT_W(4), .WRAP(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifw0.slave)
  );

  task automatic chk(input string name, input int w, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (wrap=%0d) at %0t: got %0d expected %0d", name, w, $time, act, exp);
    end
  endtask

  function automatic int occ_exp(input int w);
    int m = 0;
    for (int i = 0; i < 16; i++) begin
      if (mcnt[w][i] > 0) m |= (1 << i);
    end
    return m;
  endfunction

  // Circular scan starting at the pointer; without wrap, tags below it are skipped.
  function automatic int msearch(input int w);
    for (int k = 0; k < 16; k++) begin
      int idx = (mptr[w] + k) % 16;
      if (w == 0 && idx < mptr[w]) continue;
      if (mcnt[w][idx] > 0) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 16; i++) mcnt[w][i] = 0;
      mptr[w] = 0; mphase[w] = 0; mtag[w] = 0; mempty[w] = 0; mvalid[w] = 0;
    end
  endtask

  task automatic model_edge();
    for (int w = 0; w < 2; w++) begin
      bit accept = ins_valid && (mcnt[w][ins_tag] < 15);
      mvalid[w] = 0;
      if (mphase[w] == 1) begin
        int s = msearch(w);
        mvalid[w] = 1;
        if (s >= 0) begin
          mcnt[w][s]--;
          mptr[w] = s;
          mtag[w] = s;
          mempty[w] = 0;
        end else begin
          mtag[w] = mptr[w];
          mempty[w] = 1;
        end
      end
      if (accept) mcnt[w][ins_tag]++;
      case (mphase[w])
        0: mphase[w] = deq_req ? 1 : 0;
        1: mphase[w] = 2;
        default: mphase[w] = 0;
      endcase
    end
  endtask

  task automatic check_inst(input int w, input logic [15:0] o, input logic [3:0] p,
                            input logic v, input logic r, input logic [3:0] t,
                            input logic e, input logic ir);
    chk("occ", w, int'(o), occ_exp(w));
    chk("cur_ptr", w, int'(p), mptr[w]);
    chk("deq_valid", w, int'(v), mvalid[w]);
    chk("deq_ready", w, int'(r), (mphase[w] == 0) ? 1 : 0);
    chk("deq_tag", w, int'(t), mtag[w]);
    chk("deq_empty", w, int'(e), mempty[w]);
    chk("ins_ready", w, int'(ir), (mcnt[w][ins_tag] < 15) ? 1 : 0);
  endtask

  task automatic check_all();
    check_inst(1, ifw1.occ, ifw1.cur_ptr, ifw1.deq_valid, ifw1.deq_ready,
               ifw1.deq_tag, ifw1.deq_empty, ifw1.ins_ready);
    check_inst(0, ifw0.occ, ifw0.cur_ptr, ifw0.deq_valid, ifw0.deq_ready,
               ifw0.deq_tag, ifw0.deq_empty, ifw0.ins_ready);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_ins(input int t);
    ins_valid = 1'b1;
    ins_tag   = 4'(t);
    tick();
    ins_valid = 1'b0;
  endtask

  task automatic do_deq();
    deq_req = 1'b1;
    tick();
    deq_req = 1'b0;
    tick();
    cap_v[1] = ifw1.deq_valid; cap_tag[1] = ifw1.deq_tag;
    cap_emp[1] = ifw1.deq_empty; cap_ptr[1] = ifw1.cur_ptr;
    cap_v[0] = ifw0.deq_valid; cap_tag[0] = ifw0.deq_tag;
    cap_emp[0] = ifw0.deq_empty; cap_ptr[0] = ifw0.cur_ptr;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [15:0] o1;
    logic [15:0] o0;

    tbl.push_back('{K_RST, 0, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{K_DEQ, 0, 1, 0, 1, 0, 0, 1, 0});
    tbl.push_back('{K_INS, 5, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{K_INS, 9, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{K_INS, 2, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{K_DEQ, 0, 1, 2, 0, 2, 2, 0, 2});
    tbl.push_back('{K_DEQ, 0, 1, 5, 0, 5, 5, 0, 5});
    tbl.push_back('{K_DEQ, 0, 1, 9, 0, 9, 9, 0, 9});
    tbl.push_back('{K_INS, 12, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{K_DEQ, 0, 1, 12, 0, 12, 12, 0, 12});
    tbl.push_back('{K_INS, 12, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{K_INS, 3, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{K_DEQ, 0, 1, 12, 0, 12, 12, 0, 12});
    tbl.push_back('{K_DEQ, 0, 1, 3, 0, 3, 12, 1, 12});
    tbl.push_back('{K_RST, 0, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{K_INS, 7, 15, 0, 0, 0, 0, 0, 0});

    model_reset();
    #1;
    check_all();

    for (int n = 0; n < tbl.size(); n++) begin
      case (tbl[n].kind)
        K_RST: do_reset();
        K_INS: for (int r = 0; r < tbl[n].reps; r++) do_ins(tbl[n].tag);
        default: begin
          do_deq();
          chk("tbl_valid", 1, cap_v[1], 1);
          chk("tbl_tag", 1, cap_tag[1], tbl[n].e_tag1);
          chk("tbl_empty", 1, cap_emp[1], tbl[n].e_emp1);
          chk("tbl_ptr", 1, cap_ptr[1], tbl[n].e_ptr1);
          chk("tbl_valid", 0, cap_v[0], 1);
          chk("tbl_tag", 0, cap_tag[0], tbl[n].e_tag0);
          chk("tbl_empty", 0, cap_emp[0], tbl[n].e_emp0);
          chk("tbl_ptr", 0, cap_ptr[0], tbl[n].e_ptr0);
        end
      endcase
    end

    // Saturated counter on tag 7: a held insert must stall.
    ins_valid = 1'b1;
    ins_tag   = 4'd7;
    #1;
    chk("full_ready", 1, int'(ifw1.ins_ready), 0);
    chk("full_ready", 0, int'(ifw0.ins_ready), 0);
    chk("full_occ7", 1, int'(ifw1.occ[7]), 1);
    tick();
    tick();
    chk("stall_ready", 1, int'(ifw1.ins_ready), 0);
    ins_valid = 1'b0;
    do_deq();
    chk("full_deq_tag", 1, cap_tag[1], 7);
    chk("full_deq_tag", 0, cap_tag[0], 7);
    #1;
    chk("unstall_ready", 1, int'(ifw1.ins_ready), 1);
    chk("unstall_ready", 0, int'(ifw0.ins_ready), 1);

    // Insert of tag 4 landing on the same edge that decrements it.
    do_reset();
    do_ins(4);
    deq_req = 1'b1;
    tick();
    deq_req = 1'b0;
    ins_valid = 1'b1;
    ins_tag   = 4'd4;
    tick();
    ins_valid = 1'b0;
    chk("coll_valid", 1, int'(ifw1.deq_valid), 1);
    chk("coll_tag", 1, int'(ifw1.deq_tag), 4);
    chk("coll_occ4", 1, int'(ifw1.occ[4]), 1);
    tick();
    do_deq();
    chk("coll_second_tag", 1, cap_tag[1], 4);
    chk("coll_second_empty", 1, cap_emp[1], 0);
    chk("coll_drained_occ", 1, int'(ifw1.occ), 0);

    // Asynchronous reset while SRCH is in progress.
    do_ins(11);
    do_ins(11);
    do_deq();
    deq_req = 1'b1;
    tick();
    deq_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    o1 = ifw1.occ;
    o0 = ifw0.occ;
    chk("rst_occ", 1, int'(o1), 0);
    chk("rst_occ", 0, int'(o0), 0);
    chk("rst_ptr", 1, int'(ifw1.cur_ptr), 0);
    chk("rst_deq_ready", 1, int'(ifw1.deq_ready), 1);
    chk("rst_deq_tag", 1, int'(ifw1.deq_tag), 0);
    @(posedge clk);
    #1;
    chk("rst_no_valid", 1, int'(ifw1.deq_valid), 0);
    chk("rst_no_valid", 0, int'(ifw0.deq_valid), 0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic, biased toward a few tags so counters saturate.
    for (int c = 0; c < 600; c++) begin
      ins_valid = 1'($urandom_range(0, 1));
      ins_tag   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(0, 3) + 8);
      deq_req   = ($urandom_range(0, 3) == 0);
      tick();
    end
    ins_valid = 1'b0;
    deq_req   = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
